uart_rx_ctrl: RTL

Receive-side controller for the UART. It owns bit timing and sequencing for the serial receive path. It derives sample points from the system clock, validates start and stop bits, and assembles bytes LSB-first. Completed bytes are buffered in a small FIFO and presented to the consumer through a valid/ready handshake. It sits between the `rx` pad and any byte-consuming logic, and it reports framing and overrun errors as sticky flags.

---
 rtl/uart_rx_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, LSB-first assembly into a show-ahead byte FIFO.
// Byte visible 1 cycle after the stop-bit sample; a full FIFO drops the byte and raises overrun unless popped that cycle.

module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_dat_i,
    input  logic         out_rdy_i,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o,
    output logic         full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             pop;
    logic             push;

    assign out_vld_o = (count_q != '0);
    assign full_o    = (count_q == FULL_CNT);
    assign pop       = out_vld_o && out_rdy_i;
    // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
    assign push      = in_vld_i && (!full_o || pop);
    assign out_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end
endmodule

module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_ready,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             rx_meta_q;
    logic             rx_s_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [7:0]       sh_q;
    logic [7:0]       sh_d;
    logic             busy_q;
    logic             frame_err_q;
    logic             frame_err_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             push_vld;
    logic             frame_set;
    logic             overrun_set;
    logic             fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        push_vld  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is high again at mid-bit was noise.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    sh_d[idx_q] = rx_s_q;
                    cnt_d       = '0;
                    idx_d       = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    push_vld  = rx_s_q;
                    frame_set = !rx_s_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign overrun_set = push_vld && fifo_full && !(data_valid && rd_ready);

    // Set beats clear when both land in the same cycle.
    always_comb begin
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (frame_set) begin
            frame_err_d = 1'b1;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            busy_q      <= (state_d != S_IDLE);
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (push_vld),
        .in_dat_i  (sh_q),
        .out_rdy_i (rd_ready),
        .out_vld_o (data_valid),
        .out_dat_o (data_out),
        .full_o    (fifo_full)
    );

    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule
